// File: rtl/locking_grant_router_if.sv
// -----------------------------------------------------------------------------
// locking_grant_router_if
//
// Purpose:
//   Bundles every handshake and payload signal of the locking grant router.
//   It covers the merged grant input channel, the two per-client grant output
//   channels, and the two status flags. Clock and reset are not part of the
//   bundle.
//
// Modports:
//   master : the environment side. It drives io_in_valid/bits and the client
//            readies, and observes io_in_ready, the client valids/bits and
//            the status flags.
//   slave  : the router side. It is the mirror image of master.
//
// Signals:
//   io_in_ready / io_in_valid        merged grant handshake
//   io_in_bits_*                     merged grant payload
//   io_out_N_ready / io_out_N_valid  per-client handshake (N = 0, 1)
//   io_out_N_bits_*                  per-client registered payload
//   io_busy                          a multi-beat burst is in progress
//   io_burst_err                     sticky client_id-changed-mid-burst flag
// -----------------------------------------------------------------------------
interface locking_grant_router_if #(
   parameter int DATA_W = 64
);

   // Merged input channel
   logic              io_in_ready;
   logic              io_in_valid;
   logic [2:0]        io_in_bits_addr_beat;
   logic [1:0]        io_in_bits_client_xact_id;
   logic              io_in_bits_manager_xact_id;
   logic              io_in_bits_is_builtin_type;
   logic [3:0]        io_in_bits_g_type;
   logic [DATA_W-1:0] io_in_bits_data;
   logic              io_in_bits_client_id;

   // Client 0 output channel
   logic              io_out_0_ready;
   logic              io_out_0_valid;
   logic [2:0]        io_out_0_bits_addr_beat;
   logic [1:0]        io_out_0_bits_client_xact_id;
   logic              io_out_0_bits_manager_xact_id;
   logic              io_out_0_bits_is_builtin_type;
   logic [3:0]        io_out_0_bits_g_type;
   logic [DATA_W-1:0] io_out_0_bits_data;
   logic              io_out_0_bits_client_id;

   // Client 1 output channel
   logic              io_out_1_ready;
   logic              io_out_1_valid;
   logic [2:0]        io_out_1_bits_addr_beat;
   logic [1:0]        io_out_1_bits_client_xact_id;
   logic              io_out_1_bits_manager_xact_id;
   logic              io_out_1_bits_is_builtin_type;
   logic [3:0]        io_out_1_bits_g_type;
   logic [DATA_W-1:0] io_out_1_bits_data;
   logic              io_out_1_bits_client_id;

   // Status
   logic              io_busy;
   logic              io_burst_err;

   modport master (
      input  io_in_ready,
      output io_in_valid,
      output io_in_bits_addr_beat,
      output io_in_bits_client_xact_id,
      output io_in_bits_manager_xact_id,
      output io_in_bits_is_builtin_type,
      output io_in_bits_g_type,
      output io_in_bits_data,
      output io_in_bits_client_id,

      output io_out_0_ready,
      input  io_out_0_valid,
      input  io_out_0_bits_addr_beat,
      input  io_out_0_bits_client_xact_id,
      input  io_out_0_bits_manager_xact_id,
      input  io_out_0_bits_is_builtin_type,
      input  io_out_0_bits_g_type,
      input  io_out_0_bits_data,
      input  io_out_0_bits_client_id,

      output io_out_1_ready,
      input  io_out_1_valid,
      input  io_out_1_bits_addr_beat,
      input  io_out_1_bits_client_xact_id,
      input  io_out_1_bits_manager_xact_id,
      input  io_out_1_bits_is_builtin_type,
      input  io_out_1_bits_g_type,
      input  io_out_1_bits_data,
      input  io_out_1_bits_client_id,

      input  io_busy,
      input  io_burst_err
   );

   modport slave (
      output io_in_ready,
      input  io_in_valid,
      input  io_in_bits_addr_beat,
      input  io_in_bits_client_xact_id,
      input  io_in_bits_manager_xact_id,
      input  io_in_bits_is_builtin_type,
      input  io_in_bits_g_type,
      input  io_in_bits_data,
      input  io_in_bits_client_id,

      input  io_out_0_ready,
      output io_out_0_valid,
      output io_out_0_bits_addr_beat,
      output io_out_0_bits_client_xact_id,
      output io_out_0_bits_manager_xact_id,
      output io_out_0_bits_is_builtin_type,
      output io_out_0_bits_g_type,
      output io_out_0_bits_data,
      output io_out_0_bits_client_id,

      input  io_out_1_ready,
      output io_out_1_valid,
      output io_out_1_bits_addr_beat,
      output io_out_1_bits_client_xact_id,
      output io_out_1_bits_manager_xact_id,
      output io_out_1_bits_is_builtin_type,
      output io_out_1_bits_g_type,
      output io_out_1_bits_data,
      output io_out_1_bits_client_id,

      output io_busy,
      output io_burst_err
   );

endinterface : locking_grant_router_if

// File: rtl/locking_grant_router.sv
// -----------------------------------------------------------------------------
// locking_grant_router
//
// Purpose:
//   This is the receive-side counterpart of the two-client grant arbiter. It
//   takes the merged grant stream and steers each beat to client port 0 or 1
//   by client_id, through one registered stage.
//
//   A multi-beat grant is locked to the port chosen on its first beat until
//   BEATS multi-beat beats have been accepted, so a burst is never split
//   across clients.
//
//   A single beat, or a changed client_id, arriving inside a burst is still
//   routed to the locked port. It also raises a sticky protocol-error flag.
//
// Parameters:
//   BEATS  : beats per multi-beat grant; must be a power of two, >= 2
//   DATA_W : grant data width
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset (deassertion synchronous to clk)
//   io     : slave side of locking_grant_router_if
//            (input channel, two client channels, io_busy, io_burst_err)
//
// Timing:
//   A beat accepted in cycle t is valid at its client port in cycle t+1.
//   io_in_ready depends combinationally on the client readies only.
//   Nothing depends combinationally on io_in_valid.
// -----------------------------------------------------------------------------
module locking_grant_router #(
   parameter int BEATS  = 8,
   parameter int DATA_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   locking_grant_router_if.slave io
);

   localparam int               CNT_W   = $clog2(BEATS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic              full_q,       full_d;
   logic              dst_q,        dst_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              lock_dst_q,   lock_dst_d;
   logic              err_q,        err_d;

   // Stage payload
   logic [2:0]        addr_beat_q,  addr_beat_d;
   logic [1:0]        cxid_q,       cxid_d;
   logic              mxid_q,       mxid_d;
   logic              builtin_q,    builtin_d;
   logic [3:0]        g_type_q,     g_type_d;
   logic [DATA_W-1:0] data_q,       data_d;
   logic              client_id_q,  client_id_d;

   // --------------------------------------------------------------------------
   // Beat classification and handshake
   // --------------------------------------------------------------------------
   logic in_multi;
   logic locked;
   logic in_dst;
   logic drain;
   logic in_ready;
   logic in_fire;
   logic violation;

   // A multi-beat grant is either a builtin g_type 5 or a custom g_type 0.
   assign in_multi = ( io.io_in_bits_is_builtin_type && (io.io_in_bits_g_type == 4'h5)) ||
                     (!io.io_in_bits_is_builtin_type && (io.io_in_bits_g_type == 4'h0));

   // A non-zero burst counter means we are between the first and last beat.
   assign locked   = (cnt_q != '0);

   // Inside a burst every beat follows the lock, whatever client_id it carries.
   assign in_dst   = locked ? lock_dst_q : io.io_in_bits_client_id;

   // The stage empties only through the port it is addressed to. The other
   // port's ready is ignored, so a stalled client cannot be bypassed.
   assign drain    = full_q && (dst_q ? io.io_out_1_ready : io.io_out_0_ready);

   // Accepting while draining keeps a full-rate stream without bubbles.
   assign in_ready = !full_q || drain;
   assign in_fire  = io.io_in_valid && in_ready;

   // Inside a burst, a single beat or a client_id differing from the lock
   // is a protocol violation.
   assign violation = locked && (!in_multi || (io.io_in_bits_client_id != lock_dst_q));

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block
      // leaves a variable unassigned; a missing default would infer a latch.
      full_d      = full_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      lock_dst_d  = lock_dst_q;
      err_d       = err_q;
      addr_beat_d = addr_beat_q;
      cxid_d      = cxid_q;
      mxid_d      = mxid_q;
      builtin_d   = builtin_q;
      g_type_d    = g_type_q;
      data_d      = data_q;
      client_id_d = client_id_q;

      if (drain) begin
         full_d = 1'b0;
      end

      if (in_fire) begin
         // A load takes priority over an empty-out in the same cycle.
         full_d      = 1'b1;
         dst_d       = in_dst;
         addr_beat_d = io.io_in_bits_addr_beat;
         cxid_d      = io.io_in_bits_client_xact_id;
         mxid_d      = io.io_in_bits_manager_xact_id;
         builtin_d   = io.io_in_bits_is_builtin_type;
         g_type_d    = io.io_in_bits_g_type;
         data_d      = io.io_in_bits_data;
         client_id_d = io.io_in_bits_client_id;

         if (in_multi) begin
            // BEATS is a power of two, so the natural wrap of the counter
            // returns it to zero right after the last beat of the burst.
            cnt_d = cnt_q + CNT_ONE;
            if (!locked) begin
               lock_dst_d = io.io_in_bits_client_id;
            end
         end

         if (violation) begin
            err_d = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the payload is a single register stage, not a memory, and it
         // must read back as zero after reset. It is therefore reset along
         // with the control state.
         full_q      <= 1'b0;
         dst_q       <= 1'b0;
         cnt_q       <= '0;
         lock_dst_q  <= 1'b0;
         err_q       <= 1'b0;
         addr_beat_q <= '0;
         cxid_q      <= '0;
         mxid_q      <= 1'b0;
         builtin_q   <= 1'b0;
         g_type_q    <= '0;
         data_q      <= '0;
         client_id_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values. Blocking ones would let later lines see
         // already-updated state.
         full_q      <= full_d;
         dst_q       <= dst_d;
         cnt_q       <= cnt_d;
         lock_dst_q  <= lock_dst_d;
         err_q       <= err_d;
         addr_beat_q <= addr_beat_d;
         cxid_q      <= cxid_d;
         mxid_q      <= mxid_d;
         builtin_q   <= builtin_d;
         g_type_q    <= g_type_d;
         data_q      <= data_d;
         client_id_q <= client_id_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign io.io_in_ready    = in_ready;
   assign io.io_busy        = locked;
   assign io.io_burst_err   = err_q;

   assign io.io_out_0_valid = full_q && !dst_q;
   assign io.io_out_1_valid = full_q &&  dst_q;

   // The payload fans out to both ports; only the port whose valid is set
   // carries a meaningful beat.
   assign io.io_out_0_bits_addr_beat       = addr_beat_q;
   assign io.io_out_0_bits_client_xact_id  = cxid_q;
   assign io.io_out_0_bits_manager_xact_id = mxid_q;
   assign io.io_out_0_bits_is_builtin_type = builtin_q;
   assign io.io_out_0_bits_g_type          = g_type_q;
   assign io.io_out_0_bits_data            = data_q;
   assign io.io_out_0_bits_client_id       = client_id_q;

   assign io.io_out_1_bits_addr_beat       = addr_beat_q;
   assign io.io_out_1_bits_client_xact_id  = cxid_q;
   assign io.io_out_1_bits_manager_xact_id = mxid_q;
   assign io.io_out_1_bits_is_builtin_type = builtin_q;
   assign io.io_out_1_bits_g_type          = g_type_q;
   assign io.io_out_1_bits_data            = data_q;
   assign io.io_out_1_bits_client_id       = client_id_q;

endmodule : locking_grant_router

// File: tb/tb_locking_grant_router.sv
// -----------------------------------------------------------------------------
// tb_locking_grant_router
//
// Self-checking bench for locking_grant_router. The reference model treats
// the router as an ordered queue of delivered beats. Each entry is tagged
// with the port it must appear on, which is derived from burst-position
// arithmetic over the accepted beats.
// -----------------------------------------------------------------------------
module tb_locking_grant_router;

   localparam int BEATS  = 8;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic [2:0]        addr_beat;
      logic [1:0]        cxid;
      logic              mxid;
      logic              builtin;
      logic [3:0]        gtype;
      logic [DATA_W-1:0] data;
      logic              cid;
   } beat_t;

   typedef struct packed {
      logic  dst;
      beat_t b;
   } exp_t;

   logic clk;
   logic reset;

   locking_grant_router_if #(.DATA_W(DATA_W)) io ();

   locking_grant_router #(.BEATS(BEATS), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   exp_t exp_q[$];   // beats accepted but not yet delivered, in order
   int   m_bpos;     // multi-beat beats accepted in the current burst
   logic m_lock;     // port owning the current burst
   logic m_err;      // sticky violation flag

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic is_multi(input beat_t b);
      return b.builtin ? (b.gtype == 4'h5) : (b.gtype == 4'h0);
   endfunction

   function automatic beat_t mk(input logic cid, input logic builtin, input logic [3:0] gtype,
                                input logic [63:0] data, input logic [2:0] idx);
      beat_t b;
      b.addr_beat = idx;
      b.cxid      = 2'(idx);
      b.mxid      = idx[0];
      b.builtin   = builtin;
      b.gtype     = gtype;
      b.data      = data;
      b.cid       = cid;
      return b;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_bpos = 0;
      m_lock = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic model_accept(input beat_t b);
      exp_t e;
      logic multi;
      multi = is_multi(b);
      e.b   = b;
      if (m_bpos != 0) begin
         e.dst = m_lock;
         if (!multi || (b.cid != m_lock)) m_err = 1'b1;
      end else begin
         e.dst = b.cid;
      end
      if (multi) begin
         if (m_bpos == 0) m_lock = b.cid;
         m_bpos = (m_bpos + 1) % BEATS;
      end
      exp_q.push_back(e);
   endtask

   // Single compare point. It is called once per cycle, mid-cycle, with the
   // inputs for that cycle already applied.
   task automatic compare_all();
      logic  exp_rdy;
      logic  has;
      beat_t f;
      has     = (exp_q.size() != 0);
      exp_rdy = !has || (exp_q[0].dst ? io.io_out_1_ready : io.io_out_0_ready);
      check("in_ready",  64'(io.io_in_ready),    64'(exp_rdy));
      check("out0_valid", 64'(io.io_out_0_valid), 64'(has && !exp_q[0].dst));
      check("out1_valid", 64'(io.io_out_1_valid), 64'(has &&  exp_q[0].dst));
      check("busy",      64'(io.io_busy),        64'(m_bpos != 0));
      check("burst_err", 64'(io.io_burst_err),   64'(m_err));
      if (has) begin
         f = exp_q[0].b;
         if (!exp_q[0].dst) begin
            check("out0_data",  io.io_out_0_bits_data, f.data);
            check("out0_beat",  64'(io.io_out_0_bits_addr_beat), 64'(f.addr_beat));
            check("out0_cxid",  64'(io.io_out_0_bits_client_xact_id), 64'(f.cxid));
            check("out0_mxid",  64'(io.io_out_0_bits_manager_xact_id), 64'(f.mxid));
            check("out0_bt",    64'(io.io_out_0_bits_is_builtin_type), 64'(f.builtin));
            check("out0_gtype", 64'(io.io_out_0_bits_g_type), 64'(f.gtype));
            check("out0_cid",   64'(io.io_out_0_bits_client_id), 64'(f.cid));
         end else begin
            check("out1_data",  io.io_out_1_bits_data, f.data);
            check("out1_beat",  64'(io.io_out_1_bits_addr_beat), 64'(f.addr_beat));
            check("out1_cxid",  64'(io.io_out_1_bits_client_xact_id), 64'(f.cxid));
            check("out1_mxid",  64'(io.io_out_1_bits_manager_xact_id), 64'(f.mxid));
            check("out1_bt",    64'(io.io_out_1_bits_is_builtin_type), 64'(f.builtin));
            check("out1_gtype", 64'(io.io_out_1_bits_g_type), 64'(f.gtype));
            check("out1_cid",   64'(io.io_out_1_bits_client_id), 64'(f.cid));
         end
      end
   endtask

   // One clock cycle: apply inputs, compare, advance the clock, update the model.
   task automatic step(input logic v, input beat_t b, input logic r0, input logic r1,
                       output logic acc);
      logic ofire;
      io.io_in_valid                = v;
      io.io_in_bits_addr_beat       = b.addr_beat;
      io.io_in_bits_client_xact_id  = b.cxid;
      io.io_in_bits_manager_xact_id = b.mxid;
      io.io_in_bits_is_builtin_type = b.builtin;
      io.io_in_bits_g_type          = b.gtype;
      io.io_in_bits_data            = b.data;
      io.io_in_bits_client_id       = b.cid;
      io.io_out_0_ready             = r0;
      io.io_out_1_ready             = r1;
      #2;
      compare_all();
      acc   = v && io.io_in_ready;
      ofire = (exp_q.size() != 0) && (exp_q[0].dst ? r1 : r0);
      @(posedge clk);
      #1;
      if (ofire) void'(exp_q.pop_front());
      if (acc) model_accept(b);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b1, acc);
   endtask

   // Present a beat until it is accepted, within a bounded number of cycles.
   task automatic send(input beat_t b, input logic r0, input logic r1);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) step(1'b1, b, r0, r1, acc);
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
   endtask

   // Asynchronous reset in the middle of a cycle; release right after an edge.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      check("rst_out0_valid", 64'(io.io_out_0_valid), 64'd0);
      check("rst_out1_valid", 64'(io.io_out_1_valid), 64'd0);
      check("rst_busy",       64'(io.io_busy),        64'd0);
      check("rst_err",        64'(io.io_burst_err),   64'd0);
      check("rst_in_ready",   64'(io.io_in_ready),    64'd1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic  acc;
      beat_t b;
      logic  v, r0, r1;

      model_reset();
      reset = 1'b1;
      io.io_in_valid = 1'b0;
      io.io_in_bits_addr_beat = '0;
      io.io_in_bits_client_xact_id = '0;
      io.io_in_bits_manager_xact_id = 1'b0;
      io.io_in_bits_is_builtin_type = 1'b0;
      io.io_in_bits_g_type = '0;
      io.io_in_bits_data = '0;
      io.io_in_bits_client_id = 1'b0;
      io.io_out_0_ready = 1'b1;
      io.io_out_1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("init_out0_valid", 64'(io.io_out_0_valid), 64'd0);
      check("init_in_ready",   64'(io.io_in_ready),    64'd1);
      reset = 1'b0;

      // Single route
      send(mk(1'b1, 1'b1, 4'h3, 64'hA5, 3'd0), 1'b1, 1'b1);
      check("single_out1_valid", 64'(io.io_out_1_valid), 64'd1);
      check("single_out1_data",  io.io_out_1_bits_data,  64'hA5);
      check("single_out0_valid", 64'(io.io_out_0_valid), 64'd0);
      check("single_busy",       64'(io.io_busy),        64'd0);
      idle(1);

      // Burst lock: eight back-to-back beats on port 0
      for (int i = 0; i < BEATS; i++) begin
         step(1'b1, mk(1'b0, 1'b1, 4'h5, 64'h1000 + 64'(i), 3'(i)), 1'b1, 1'b1, acc);
         check("burst_acc",        64'(acc),               64'd1);
         check("burst_out0_valid", 64'(io.io_out_0_valid), 64'd1);
         check("burst_data",       io.io_out_0_bits_data,  64'h1000 + 64'(i));
         check("burst_busy",       64'(io.io_busy),        64'(i != BEATS - 1));
      end
      idle(1);

      // Backpressure after beat 3
      for (int i = 0; i < 3; i++) send(mk(1'b0, 1'b1, 4'h5, 64'h2000 + 64'(i), 3'(i)), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, mk(1'b0, 1'b1, 4'h5, 64'h2003, 3'd3), 1'b0, 1'b1, acc);
         check("bp_acc",      64'(acc),              64'd0);
         check("bp_in_ready", 64'(io.io_in_ready),   64'd0);
         check("bp_busy",     64'(io.io_busy),       64'd1);
         check("bp_hold",     io.io_out_0_bits_data, 64'h2002);
      end
      for (int i = 3; i < BEATS; i++) send(mk(1'b0, 1'b1, 4'h5, 64'h2000 + 64'(i), 3'(i)), 1'b1, 1'b1);
      check("bp_end_busy", 64'(io.io_busy), 64'd0);
      idle(1);

      // Alternating singles
      for (int i = 0; i < 4; i++) begin
         step(1'b1, mk(1'(i), 1'b1, 4'h3, 64'h3000 + 64'(i), 3'd0), 1'b1, 1'b1, acc);
         check("alt_acc",        64'(acc),               64'd1);
         check("alt_out1_valid", 64'(io.io_out_1_valid), 64'(i % 2));
         check("alt_err",        64'(io.io_burst_err),   64'd0);
      end
      idle(1);

      // Mid-burst client flip on beat 4
      for (int i = 0; i < BEATS; i++) begin
         send(mk(1'(i == 3), 1'b0, 4'h0, 64'h4000 + 64'(i), 3'(i)), 1'b1, 1'b1);
         if (i == 3) begin
            check("flip_out0_valid", 64'(io.io_out_0_valid), 64'd1);
            check("flip_cid",        64'(io.io_out_0_bits_client_id), 64'd1);
            check("flip_err",        64'(io.io_burst_err), 64'd1);
         end
      end
      idle(2);
      send(mk(1'b1, 1'b1, 4'h3, 64'h4100, 3'd0), 1'b1, 1'b1);
      check("flip_err_sticky", 64'(io.io_burst_err), 64'd1);

      // Reset mid-burst with the stage full
      for (int i = 0; i < 5; i++) send(mk(1'b0, 1'b1, 4'h5, 64'h5000 + 64'(i), 3'(i)), 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, acc);
      check("pre_rst_busy", 64'(io.io_busy), 64'd1);
      async_reset();
      send(mk(1'b1, 1'b1, 4'h3, 64'h5100, 3'd0), 1'b1, 1'b1);
      check("post_rst_out1_valid", 64'(io.io_out_1_valid), 64'd1);
      check("post_rst_out0_valid", 64'(io.io_out_0_valid), 64'd0);
      idle(1);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) async_reset();
         v  = ($urandom_range(0, 3) != 0);
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         if (m_bpos != 0 && $urandom_range(0, 15) != 0) begin
            b = mk(m_lock, 1'($urandom_range(0, 1)), 4'h0, {$urandom, $urandom}, 3'(m_bpos));
            if (b.builtin) b.gtype = 4'h5;
         end else begin
            case ($urandom_range(0, 4))
               0: b = mk(1'($urandom), 1'b1, 4'h5, {$urandom, $urandom}, 3'd0);
               1: b = mk(1'($urandom), 1'b0, 4'h0, {$urandom, $urandom}, 3'd0);
               2: b = mk(1'($urandom), 1'b1, 4'h3, {$urandom, $urandom}, 3'd0);
               3: b = mk(1'($urandom), 1'b0, 4'h7, {$urandom, $urandom}, 3'd0);
               default: b = mk(1'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom}, 3'($urandom));
            endcase
         end
         step(v, b, r0, r1, acc);
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_locking_grant_router
